// File: rtl/imem_load_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_load_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE,
    ERROR
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned ADDR_STEP      = 4;

  function automatic int unsigned calc_max_words(input int unsigned depth);
    return depth / BYTES_PER_WORD;
  endfunction

endpackage

// File: rtl/imem_load_ctrl_byte_packer.sv
// Packs an MSB-first byte stream into 32-bit words; word_full marks the 4th byte.
module byte_packer
  import imem_load_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [31:0] sr;
  logic [1:0]  cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sr  <= {sr[23:0], byte_in};
      cnt <= cnt + 2'd1;
    end
  end

  assign word      = sr;
  assign word_full = shift_en && (cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_load_ctrl.sv
// Program-load controller: packs host bytes into words, writes them to imem, stalls the CPU until done.
module imem_load_ctrl
  import imem_load_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              cpu_stall,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned MAX_WORDS = calc_max_words(DEPTH);

  state_t            state, next_state;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        word_cnt;
  logic [7:0]        count_lat;
  logic              clear;
  logic              shift_en;
  logic              word_full;

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .shift_en  (shift_en),
    .byte_in   (byte_data),
    .word      (mem_wdata),
    .word_full (word_full)
  );

  always_comb begin
    next_state = state;
    byte_ready = 1'b0;
    clear      = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          clear = 1'b1;
          if (word_count == 8'd0)
            next_state = DONE;
          else if (word_count > 8'(MAX_WORDS))
            next_state = ERROR;
          else
            next_state = LOAD;
        end
      end
      LOAD: begin
        byte_ready = 1'b1;
        if (word_full)
          next_state = WRITE;
      end
      WRITE: begin
        if ((word_cnt + 8'd1) == count_lat)
          next_state = DONE;
        else
          next_state = LOAD;
      end
      default: next_state = IDLE;
    endcase
  end

  assign shift_en = byte_ready && byte_valid;
  assign mem_addr = (state == LOAD || state == WRITE) ? load_addr : fetch_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      load_addr <= '0;
      word_cnt  <= '0;
      count_lat <= '0;
      mem_we    <= 1'b0;
      cpu_stall <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= next_state;
      if (clear) begin
        load_addr <= '0;
        word_cnt  <= '0;
        count_lat <= word_count;
      end else if (state == WRITE) begin
        load_addr <= load_addr + ADDR_W'(ADDR_STEP);
        word_cnt  <= word_cnt + 8'd1;
      end
      // Status flags are registered from next_state so they align with the state they describe.
      mem_we    <= (next_state == WRITE);
      cpu_stall <= (next_state != DONE);
      busy      <= (next_state == LOAD) || (next_state == WRITE);
      done      <= (next_state == DONE);
      err       <= (next_state == ERROR);
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: session table, directed corner sequences, random sessions.
module tb_imem_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [31:0] fetch_addr;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        cpu_stall;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  imem_load_ctrl #(.DEPTH(256), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .fetch_addr (fetch_addr),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .cpu_stall  (cpu_stall),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
  end

  typedef struct {
    logic [7:0] wc;
    int         gap;
    bit         exp_done;
    bit         exp_err;
    int         exp_writes;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3);
    return 32'(b0) * 32'h0100_0000 + 32'(b1) * 32'h0001_0000 + 32'(b2) * 32'h100 + 32'(b3);
  endfunction

  task automatic do_start(input logic [7:0] wc);
    start      = 1'b1;
    word_count = wc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, output int hs);
    hs         = -1;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 50; i++) begin
      if (byte_ready) begin
        hs = cyc;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    byte_valid = 1'b0;
    if (hs < 0) check("byte_ready timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_flag(input bit want_err, output int at);
    at = -1;
    for (int i = 0; i < 400; i++) begin
      if (want_err ? err : done) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    if (at < 0) check("done/err timeout", 64'd0, 64'd1);
  endtask

  task automatic run_session(input string tag, input logic [7:0] wc, input int gap,
                             input bit exp_done, input bit exp_err, input int exp_writes);
    logic [7:0]  bytes[$];
    logic [31:0] exp_d[$];
    int          nw;
    int          hs;
    int          at;
    nw = exp_writes;
    wa_q.delete();
    wd_q.delete();
    for (int i = 0; i < nw * 4; i++) bytes.push_back(8'($urandom));
    for (int w = 0; w < nw; w++)
      exp_d.push_back(pack(bytes[4*w], bytes[4*w+1], bytes[4*w+2], bytes[4*w+3]));
    do_start(wc);
    foreach (bytes[i]) begin
      if (gap > 0) repeat ($urandom_range(0, gap)) @(negedge clk);
      push_byte(bytes[i], hs);
    end
    wait_flag(exp_err, at);
    repeat (3) @(negedge clk);
    check({tag, " done"}, 64'(done), 64'(exp_done));
    check({tag, " err"}, 64'(err), 64'(exp_err));
    check({tag, " cpu_stall"}, 64'(cpu_stall), 64'(!exp_done));
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " write count"}, 64'(wa_q.size()), 64'(nw));
    for (int w = 0; w < nw && w < wa_q.size(); w++) begin
      check($sformatf("%s addr[%0d]", tag, w), 64'(wa_q[w]), 64'(4 * w));
      check($sformatf("%s data[%0d]", tag, w), 64'(wd_q[w]), 64'(exp_d[w]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[6];
    logic [7:0]  seq[8];
    int          hs0, hs, at;
    logic [7:0]  wc;
    bit          e;

    tbl[0] = '{wc: 8'd0,   gap: 0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 0};
    tbl[1] = '{wc: 8'd1,   gap: 0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 1};
    tbl[2] = '{wc: 8'd64,  gap: 1, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 64};
    tbl[3] = '{wc: 8'd65,  gap: 0, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 0};
    tbl[4] = '{wc: 8'd200, gap: 0, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 0};
    tbl[5] = '{wc: 8'd5,   gap: 3, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 5};

    seq = '{8'h4C, 8'h40, 8'h00, 8'h00, 8'h4C, 8'h80, 8'h00, 8'h01};

    rst_n      = 1'b0;
    start      = 1'b0;
    word_count = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    fetch_addr = 32'h10;

    // Reset state
    #12;
    check("rst cpu_stall", 64'(cpu_stall), 64'd1);
    check("rst done", 64'(done), 64'd0);
    check("rst err", 64'(err), 64'd0);
    check("rst mem_we", 64'(mem_we), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst byte_ready", 64'(byte_ready), 64'd0);
    check("rst mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst mem_addr", 64'(mem_addr), 64'h10);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle cpu_stall", 64'(cpu_stall), 64'd1);
    check("idle mem_addr", 64'(mem_addr), 64'h10);

    // Two-word back-to-back load
    wa_q.delete(); wd_q.delete();
    do_start(8'd2);
    check("load busy", 64'(busy), 64'd1);
    check("load byte_ready", 64'(byte_ready), 64'd1);
    push_byte(seq[0], hs0);
    for (int i = 1; i < 8; i++) push_byte(seq[i], hs);
    wait_flag(1'b0, at);
    check("b2b done latency", 64'(at - hs0), 64'd10);
    check("b2b cpu_stall", 64'(cpu_stall), 64'd0);
    check("b2b mem_addr mux", 64'(mem_addr), 64'h10);
    check("b2b writes", 64'(wa_q.size()), 64'd2);
    if (wa_q.size() == 2) begin
      check("b2b addr0", 64'(wa_q[0]), 64'd0);
      check("b2b data0", 64'(wd_q[0]), 64'h4C40_0000);
      check("b2b addr1", 64'(wa_q[1]), 64'd4);
      check("b2b data1", 64'(wd_q[1]), 64'h4C80_0001);
    end

    // Seven-cycle byte_valid gap mid-word
    wa_q.delete(); wd_q.delete();
    do_start(8'd2);
    check("restart clears done", 64'(done), 64'd0);
    push_byte(seq[0], hs0);
    push_byte(seq[1], hs);
    repeat (7) @(negedge clk);
    for (int i = 2; i < 8; i++) push_byte(seq[i], hs);
    wait_flag(1'b0, at);
    check("gap done latency", 64'(at - hs0), 64'd17);
    check("gap writes", 64'(wa_q.size()), 64'd2);
    if (wa_q.size() == 2) begin
      check("gap data0", 64'(wd_q[0]), 64'h4C40_0000);
      check("gap data1", 64'(wd_q[1]), 64'h4C80_0001);
    end

    // Oversize request, then an empty session
    wa_q.delete(); wd_q.delete();
    do_start(8'd65);
    check("oversize err", 64'(err), 64'd1);
    check("oversize done", 64'(done), 64'd0);
    check("oversize byte_ready", 64'(byte_ready), 64'd0);
    byte_valid = 1'b1;
    repeat (5) @(negedge clk);
    byte_valid = 1'b0;
    check("oversize writes", 64'(wa_q.size()), 64'd0);
    check("oversize cpu_stall", 64'(cpu_stall), 64'd1);
    do_start(8'd0);
    check("empty done", 64'(done), 64'd1);
    check("empty err", 64'(err), 64'd0);
    check("empty cpu_stall", 64'(cpu_stall), 64'd0);

    // start pulse inside a 3-word load is ignored
    wa_q.delete(); wd_q.delete();
    do_start(8'd3);
    for (int i = 0; i < 5; i++) push_byte(8'(i + 1), hs);
    start      = 1'b1;
    word_count = 8'd0;
    push_byte(8'h06, hs);
    start = 1'b0;
    for (int i = 6; i < 12; i++) push_byte(8'(i + 1), hs);
    wait_flag(1'b0, at);
    check("ignored-start writes", 64'(wa_q.size()), 64'd3);
    if (wa_q.size() == 3) begin
      check("ignored-start addr2", 64'(wa_q[2]), 64'd8);
      check("ignored-start data1", 64'(wd_q[1]), 64'h0506_0708);
    end

    // Reset after 6 bytes of a 2-word load
    wa_q.delete(); wd_q.delete();
    do_start(8'd2);
    for (int i = 0; i < 6; i++) push_byte(seq[i], hs);
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst byte_ready", 64'(byte_ready), 64'd0);
    check("midrst cpu_stall", 64'(cpu_stall), 64'd1);
    check("midrst mem_we", 64'(mem_we), 64'd0);
    check("midrst mem_wdata", 64'(mem_wdata), 64'd0);
    check("midrst mem_addr", 64'(mem_addr), 64'h10);
    check("midrst done", 64'(done), 64'd0);
    check("midrst writes", 64'(wa_q.size()), 64'd1);
    if (wa_q.size() == 1) check("midrst addr0", 64'(wa_q[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Session table
    foreach (tbl[i])
      run_session($sformatf("tbl%0d", i), tbl[i].wc, tbl[i].gap,
                  tbl[i].exp_done, tbl[i].exp_err, tbl[i].exp_writes);

    // Random sessions against the rule-based model
    for (int r = 0; r < 20; r++) begin
      wc = 8'($urandom_range(0, 70));
      e  = (wc > 8'd64);
      run_session($sformatf("rnd%0d", r), wc, $urandom_range(0, 3),
                  !e, e, e ? 0 : int'(wc));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
